// File: rtl/cm_link_ctrl.sv
// Half-duplex 4-phase req/ack byte controller for the shared cm bus.
// Optional handshake timeout is built when CM_LINK_TIMEOUT_EN is defined.
module cm_link_ctrl #(
   parameter int unsigned SETUP_CYC   = 2,
   parameter int unsigned TIMEOUT_CYC = 1024
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [7:0] tx_data,
   input  logic       tx_valid,
   output logic       tx_ready,
   output logic [7:0] rx_data,
   output logic       rx_valid,
   output logic [7:0] bus_data_out,
   output logic       bus_drive_en,
   input  logic [7:0] bus_data_in,
   input  logic       mcu_req,
   output logic       fpga_ack,
   output logic       fpga_req,
   input  logic       mcu_ack,
   output logic       busy,
   output logic       timeout_err
);

   localparam int unsigned DW  = 8;
   localparam int unsigned SCW = 4;
   localparam logic [SCW-1:0] SETUP_LAST = SCW'(SETUP_CYC - 1);

   if (SETUP_CYC < 1 || SETUP_CYC > 15 || TIMEOUT_CYC < 2 || TIMEOUT_CYC > 65535) begin : g_param_check
      $error("cm_link_ctrl: SETUP_CYC or TIMEOUT_CYC out of range");
   end

   typedef enum logic [2:0] {
      IDLE     = 3'd0,
      RX_ACK   = 3'd1,
      TX_SETUP = 3'd2,
      TX_REQ   = 3'd3,
      TX_REL   = 3'd4
   } state_t;

   state_t         state, state_nxt;
   logic           req_meta, req_s, ack_meta, ack_s;
   logic [SCW-1:0] setup_cnt, setup_cnt_nxt;
   logic           tx_ready_nxt, rx_valid_nxt, drive_nxt, fpga_ack_nxt, fpga_req_nxt, busy_nxt;
   logic [DW-1:0]  rx_data_nxt, bus_data_out_nxt;

   // Two-flop synchronisers for the asynchronous MCU handshake lines
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         req_meta <= 1'b0;
         req_s    <= 1'b0;
         ack_meta <= 1'b0;
         ack_s    <= 1'b0;
      end else begin
         req_meta <= mcu_req;
         req_s    <= req_meta;
         ack_meta <= mcu_ack;
         ack_s    <= ack_meta;
      end
   end

`ifdef CM_LINK_TIMEOUT_EN
   localparam int unsigned TCW = 16;
   localparam logic [TCW-1:0] WAIT_LAST = TCW'(TIMEOUT_CYC - 1);
   logic [TCW-1:0] wait_cnt, wait_cnt_nxt;
   logic           timeout_nxt;
`endif

   // Next-state and next-output logic
   always_comb begin
      state_nxt        = state;
      setup_cnt_nxt    = setup_cnt;
      rx_data_nxt      = rx_data;
      rx_valid_nxt     = 1'b0;
      bus_data_out_nxt = bus_data_out;
      drive_nxt        = bus_drive_en;
      fpga_ack_nxt     = fpga_ack;
      fpga_req_nxt     = fpga_req;
`ifdef CM_LINK_TIMEOUT_EN
      timeout_nxt      = 1'b0;
      wait_cnt_nxt     = TCW'(0);
`endif
      case (state)
         IDLE: begin
            if (req_s) begin
               rx_data_nxt  = bus_data_in;
               rx_valid_nxt = 1'b1;
               fpga_ack_nxt = 1'b1;
               state_nxt    = RX_ACK;
            end else if (tx_valid) begin
               bus_data_out_nxt = tx_data;
               drive_nxt        = 1'b1;
               setup_cnt_nxt    = SCW'(0);
               state_nxt        = TX_SETUP;
            end
         end
         RX_ACK: begin
            if (!req_s) begin
               fpga_ack_nxt = 1'b0;
               state_nxt    = IDLE;
            end
         end
         TX_SETUP: begin
            if (setup_cnt == SETUP_LAST) begin
               fpga_req_nxt = 1'b1;
               state_nxt    = TX_REQ;
            end else begin
               setup_cnt_nxt = setup_cnt + SCW'(1);
            end
         end
         TX_REQ: begin
            if (ack_s) begin
               fpga_req_nxt = 1'b0;
               drive_nxt    = 1'b0;
               state_nxt    = TX_REL;
            end
         end
         TX_REL: begin
            if (!ack_s) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
`ifdef CM_LINK_TIMEOUT_EN
      // Abort a stalled wait state; a normal transition in the same cycle wins
      if ((state == RX_ACK || state == TX_REQ || state == TX_REL) && state_nxt == state) begin
         if (wait_cnt == WAIT_LAST) begin
            timeout_nxt  = 1'b1;
            fpga_req_nxt = 1'b0;
            fpga_ack_nxt = 1'b0;
            drive_nxt    = 1'b0;
            state_nxt    = IDLE;
         end else begin
            wait_cnt_nxt = wait_cnt + TCW'(1);
         end
      end
`endif
      // req_meta is next cycle's req_s, so tx_ready tracks !req_s exactly
      tx_ready_nxt = (state_nxt == IDLE) && !req_meta;
      busy_nxt     = (state_nxt != IDLE);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state        <= IDLE;
         setup_cnt    <= SCW'(0);
         tx_ready     <= 1'b0;
         rx_data      <= DW'(0);
         rx_valid     <= 1'b0;
         bus_data_out <= DW'(0);
         bus_drive_en <= 1'b0;
         fpga_ack     <= 1'b0;
         fpga_req     <= 1'b0;
         busy         <= 1'b0;
      end else begin
         state        <= state_nxt;
         setup_cnt    <= setup_cnt_nxt;
         tx_ready     <= tx_ready_nxt;
         rx_data      <= rx_data_nxt;
         rx_valid     <= rx_valid_nxt;
         bus_data_out <= bus_data_out_nxt;
         bus_drive_en <= drive_nxt;
         fpga_ack     <= fpga_ack_nxt;
         fpga_req     <= fpga_req_nxt;
         busy         <= busy_nxt;
      end
   end

`ifdef CM_LINK_TIMEOUT_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wait_cnt    <= TCW'(0);
         timeout_err <= 1'b0;
      end else begin
         wait_cnt    <= wait_cnt_nxt;
         timeout_err <= timeout_nxt;
      end
   end
`else
   assign timeout_err = 1'b0;
`endif

endmodule
